// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : axi_lite_regfile
//  Purpose  : AXI4-Lite responder exposing NUM_REGS 32-bit read/write control
//             registers with byte strobes, a flat register output vector and
//             per-register write pulses. The write and read paths are
//             independent, so one of each may be in flight at the same time.
//  Options  : AXI_REGFILE_PRIV_EN - when defined, unprivileged accesses
//             (awprot[0]/arprot[0] = 0) are rejected with SLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     aclk,
    input  logic                     areset,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]    awaddr,
    input  logic [2:0]               awprot,
    input  logic                     awvalid,
    output logic                     awready,
    // write data channel
    input  logic [31:0]              wdata,
    input  logic [3:0]               wstrb,
    input  logic                     wvalid,
    output logic                     wready,
    // write response channel
    output logic [1:0]               bresp,
    output logic                     bvalid,
    input  logic                     bready,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]    araddr,
    input  logic [2:0]               arprot,
    input  logic                     arvalid,
    output logic                     arready,
    // read data channel
    output logic [31:0]              rdata,
    output logic [1:0]               rresp,
    output logic                     rvalid,
    input  logic                     rready,
    // fabric side
    output logic [32*NUM_REGS-1:0]   regs,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int         c_idx_w  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int         c_cmp_w  = ADDR_WIDTH + 10;
    localparam logic [1:0] c_okay   = 2'b00;
    localparam logic [1:0] c_slverr = 2'b10;

    localparam logic [0:0] c_w_idle = 1'b0;
    localparam logic [0:0] c_w_resp = 1'b1;
    localparam logic [0:0] c_r_idle = 1'b0;
    localparam logic [0:0] c_r_data = 1'b1;

    // Address is in range when it lies at or above BASE_ADDR and the word
    // index falls below NUM_REGS; the compare is widened so NUM_REGS never
    // truncates for narrow address buses.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && (c_cmp_w'(off >> 2) < c_cmp_w'(NUM_REGS));
    endfunction

    function automatic logic [c_idx_w-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return c_idx_w'(off >> 2);
    endfunction

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    logic [0:0]             r_wstate;
    logic                   r_awready;
    logic                   r_wready;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_aw_held;
    logic [ADDR_WIDTH-1:0]  r_aw_addr;
    logic [2:0]             r_aw_prot;
    logic                   r_w_held;
    logic [31:0]            r_w_data;
    logic [3:0]             r_w_strb;

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_commit;
    logic [ADDR_WIDTH-1:0]  w_wr_addr;
    logic [2:0]             w_wr_prot;
    logic [31:0]            w_wr_data;
    logic [3:0]             w_wr_strb;
    logic                   w_wr_ok;
    logic [c_idx_w-1:0]     w_wr_idx;
    logic                   w_aw_held_nxt;
    logic                   w_w_held_nxt;
    logic                   w_bvalid_nxt;

    // Merge held and live channel contents and decide whether a write commits.
    always_comb begin
        w_aw_hs   = awvalid & r_awready;
        w_w_hs    = wvalid & r_wready;
        w_commit  = (r_wstate == c_w_idle) && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
        w_wr_addr = r_aw_held ? r_aw_addr : awaddr;
        w_wr_prot = r_aw_held ? r_aw_prot : awprot;
        w_wr_data = r_w_held  ? r_w_data  : wdata;
        w_wr_strb = r_w_held  ? r_w_strb  : wstrb;
        w_wr_idx  = addr_index(w_wr_addr);
`ifdef AXI_REGFILE_PRIV_EN
        w_wr_ok   = addr_in_range(w_wr_addr) && w_wr_prot[0];
`else
        w_wr_ok   = addr_in_range(w_wr_addr);
`endif
        w_aw_held_nxt = w_commit ? 1'b0 : (r_aw_held | w_aw_hs);
        w_w_held_nxt  = w_commit ? 1'b0 : (r_w_held | w_w_hs);
        if (w_commit) begin
            w_bvalid_nxt = 1'b1;
        end else if (r_bvalid && bready) begin
            w_bvalid_nxt = 1'b0;
        end else begin
            w_bvalid_nxt = r_bvalid;
        end
    end

    // Write FSM: collect AW/W, issue the B response, register the readies.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wstate  <= c_w_idle;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= c_okay;
            r_aw_held <= 1'b0;
            r_aw_addr <= '0;
            r_aw_prot <= '0;
            r_w_held  <= 1'b0;
            r_w_data  <= '0;
            r_w_strb  <= '0;
        end else begin
            r_awready <= !w_aw_held_nxt && !w_bvalid_nxt;
            r_wready  <= !w_w_held_nxt && !w_bvalid_nxt;
            r_aw_held <= w_aw_held_nxt;
            r_w_held  <= w_w_held_nxt;
            if (w_aw_hs) begin
                r_aw_addr <= awaddr;
                r_aw_prot <= awprot;
            end
            if (w_w_hs) begin
                r_w_data <= wdata;
                r_w_strb <= wstrb;
            end
            case (r_wstate)
                c_w_idle: begin
                    if (w_commit) begin
                        r_wstate <= c_w_resp;
                        r_bvalid <= 1'b1;
                        r_bresp  <= w_wr_ok ? c_okay : c_slverr;
                    end
                end
                c_w_resp: begin
                    if (bready) begin
                        r_wstate <= c_w_idle;
                        r_bvalid <= 1'b0;
                    end
                end
                default: begin
                    r_wstate <= c_w_idle;
                    r_bvalid <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register storage, one block per register
    // ------------------------------------------------------------------
    logic [32*NUM_REGS-1:0] w_regs_flat;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs
        localparam logic [c_idx_w-1:0] c_my_idx = c_idx_w'(i);
        logic [31:0] r_reg;
        logic        r_pulse;

        // Apply strobed bytes on an accepted write and flag the write.
        always_ff @(posedge aclk or posedge areset) begin
            if (areset) begin
                r_reg   <= '0;
                r_pulse <= 1'b0;
            end else begin
                r_pulse <= w_commit && w_wr_ok && (w_wr_idx == c_my_idx);
                if (w_commit && w_wr_ok && (w_wr_idx == c_my_idx)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (w_wr_strb[k]) begin
                            r_reg[8*k +: 8] <= w_wr_data[8*k +: 8];
                        end
                    end
                end
            end
        end

        assign w_regs_flat[32*i +: 32] = r_reg;
        assign wr_pulse[i]             = r_pulse;
    end

    assign regs = w_regs_flat;

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    logic [0:0]          r_rstate;
    logic                r_arready;
    logic                r_rvalid;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;

    logic                w_ar_hs;
    logic                w_rd_ok;
    logic [c_idx_w-1:0]  w_rd_idx;

    // Decode the read address presented this cycle.
    always_comb begin
        w_ar_hs  = arvalid & r_arready;
        w_rd_idx = addr_index(araddr);
`ifdef AXI_REGFILE_PRIV_EN
        w_rd_ok  = addr_in_range(araddr) && arprot[0];
`else
        w_rd_ok  = addr_in_range(araddr);
`endif
    end

    // Read FSM: sample the register (pre-write value on a same-cycle commit)
    // and hold the R beat until the master accepts it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rstate  <= c_r_idle;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= c_okay;
        end else begin
            case (r_rstate)
                c_r_idle: begin
                    if (w_ar_hs) begin
                        r_rstate  <= c_r_data;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_ok ? w_regs_flat[{w_rd_idx, 5'b00000} +: 32] : 32'h0;
                        r_rresp   <= w_rd_ok ? c_okay : c_slverr;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                c_r_data: begin
                    if (rready) begin
                        r_rstate  <= c_r_idle;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= c_r_idle;
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                end
            endcase
        end
    end

    assign awready = r_awready;
    assign wready  = r_wready;
    assign bvalid  = r_bvalid;
    assign bresp   = r_bresp;
    assign arready = r_arready;
    assign rvalid  = r_rvalid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;

    // Protection bits that carry no meaning in this build.
    logic w_unused;
    assign w_unused = ^{awprot, arprot, w_wr_prot};

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_lite_regfile
//  Purpose  : Directed self-checking bench for axi_lite_regfile.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_regfile;

    localparam int c_num_regs = 16;

    logic                    aclk;
    logic                    areset;
    logic [31:0]             awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [31:0]             araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;
    logic [32*c_num_regs-1:0] regs;
    logic [c_num_regs-1:0]   wr_pulse;

    int n_cmp;
    int n_err;

    axi_lite_regfile #(
        .ADDR_WIDTH (32),
        .NUM_REGS   (c_num_regs),
        .BASE_ADDR  (32'h0)
    ) u_dut (
        .aclk     (aclk),
        .areset   (areset),
        .awaddr   (awaddr),
        .awprot   (awprot),
        .awvalid  (awvalid),
        .awready  (awready),
        .wdata    (wdata),
        .wstrb    (wstrb),
        .wvalid   (wvalid),
        .wready   (wready),
        .bresp    (bresp),
        .bvalid   (bvalid),
        .bready   (bready),
        .araddr   (araddr),
        .arprot   (arprot),
        .arvalid  (arvalid),
        .arready  (arready),
        .rdata    (rdata),
        .rresp    (rresp),
        .rvalid   (rvalid),
        .rready   (rready),
        .regs     (regs),
        .wr_pulse (wr_pulse)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return regs[32*i +: 32];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // AW and W presented together for one cycle (readies are high on entry).
    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic [2:0] p);
        awaddr  = a;
        awprot  = p;
        awvalid = 1'b1;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
    endtask

    task automatic b_ack();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        araddr  = a;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
    endtask

    task automatic r_ack();
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        areset  = 1'b1;
        awaddr  = '0;
        awprot  = 3'b001;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arprot  = 3'b001;
        arvalid = 1'b0;
        rready  = 1'b0;

        // reset state
        repeat (3) tick();
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_arready", arready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_reg2", reg_of(2), 0);
        check("rst_pulse", wr_pulse, 0);
        areset = 1'b0;
        tick();
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        check("rel_arready", arready, 1);

        // AW and W in the same cycle
        wr(32'h8, 32'hDEADBEEF, 4'hF, 3'b001);
        check("w1_bvalid", bvalid, 1);
        check("w1_bresp", bresp, 2'b00);
        check("w1_reg2", reg_of(2), 32'hDEADBEEF);
        check("w1_pulse", wr_pulse, 16'h0004);
        check("w1_awready", awready, 0);
        tick();
        check("w1_pulse_off", wr_pulse, 0);
        check("w1_bvalid_hold", bvalid, 1);
        b_ack();
        check("w1_bdone", bvalid, 0);
        check("w1_awready_back", awready, 1);

        // W two cycles before AW, low byte only
        wdata  = 32'h000000AA;
        wstrb  = 4'b0001;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("w2_wready_low", wready, 0);
        check("w2_awready_high", awready, 1);
        tick();
        check("w2_no_commit", bvalid, 0);
        awaddr  = 32'h8;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check("w2_bvalid", bvalid, 1);
        check("w2_reg2", reg_of(2), 32'hDEADBEAA);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("w2_awready_stall", awready, 0);
            check("w2_wready_stall", wready, 0);
            check("w2_bvalid_stall", bvalid, 1);
            check("w2_bresp_stall", bresp, 2'b00);
        end
        b_ack();

        // in-range read, R stalled a cycle
        rd(32'h8);
        check("r1_rvalid", rvalid, 1);
        check("r1_rdata", rdata, 32'hDEADBEAA);
        check("r1_rresp", rresp, 2'b00);
        check("r1_arready", arready, 0);
        tick();
        check("r1_rdata_stable", rdata, 32'hDEADBEAA);
        r_ack();
        check("r1_rdone", rvalid, 0);
        check("r1_arready_back", arready, 1);

        // out-of-range read and write
        rd(32'h40);
        check("oor_rresp", rresp, 2'b10);
        check("oor_rdata", rdata, 0);
        r_ack();
        wr(32'h40, 32'hFFFFFFFF, 4'hF, 3'b001);
        check("oor_bresp", bresp, 2'b10);
        check("oor_pulse", wr_pulse, 0);
        check("oor_reg2", reg_of(2), 32'hDEADBEAA);
        check("oor_reg15", reg_of(15), 0);
        b_ack();

        // read and write commit on the same register in the same cycle
        wr(32'hC, 32'h1, 4'hF, 3'b001);
        b_ack();
        araddr  = 32'hC;
        arvalid = 1'b1;
        wr(32'hC, 32'h2, 4'hF, 3'b001);
        arvalid = 1'b0;
        check("rw_rdata_old", rdata, 32'h1);
        check("rw_reg3_new", reg_of(3), 32'h2);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        rd(32'hC);
        check("rw_rdata_new", rdata, 32'h2);
        r_ack();

        // all-zero strobe: no change, OKAY, pulse still fires
        wr(32'hC, 32'hFFFFFFFF, 4'h0, 3'b001);
        check("s0_bresp", bresp, 2'b00);
        check("s0_pulse", wr_pulse, 16'h0008);
        check("s0_reg3", reg_of(3), 32'h2);
        b_ack();

        // reset while both responses are pending
        araddr  = 32'h8;
        arvalid = 1'b1;
        wr(32'h4, 32'h12345678, 4'hF, 3'b001);
        arvalid = 1'b0;
        check("mr_bvalid_pre", bvalid, 1);
        check("mr_rvalid_pre", rvalid, 1);
        areset = 1'b1;
        #1;
        check("mr_bvalid", bvalid, 0);
        check("mr_rvalid", rvalid, 0);
        check("mr_awready", awready, 0);
        check("mr_arready", arready, 0);
        check("mr_rdata", rdata, 0);
        check("mr_reg1", reg_of(1), 0);
        check("mr_reg2", reg_of(2), 0);
        check("mr_pulse", wr_pulse, 0);
        tick();
        areset = 1'b0;
        tick();
        check("mr_awready_back", awready, 1);
        check("mr_wready_back", wready, 1);
        check("mr_arready_back", arready, 1);

        // privilege bit on the write address channel
        wr(32'h0, 32'h55, 4'hF, 3'b000);
`ifdef AXI_REGFILE_PRIV_EN
        check("pv_bresp_unpriv", bresp, 2'b10);
        check("pv_reg0_unpriv", reg_of(0), 0);
        check("pv_pulse_unpriv", wr_pulse, 0);
`else
        check("pv_bresp_unpriv", bresp, 2'b00);
        check("pv_reg0_unpriv", reg_of(0), 32'h55);
`endif
        b_ack();
        wr(32'h0, 32'h66, 4'hF, 3'b001);
        check("pv_bresp_priv", bresp, 2'b00);
        check("pv_reg0_priv", reg_of(0), 32'h66);
        b_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

AXI4-Lite responder exposing NUM_REGS 32-bit read/write control registers to fabric logic. Sits on the slave side of the team's AXI4-Lite bus, accepts single-beat reads and writes from any master, applies byte strobes, and drives the register contents onto a flat output vector for the surrounding datapath. One write and one read may be in flight concurrently; the two paths are independent.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte address width
- NUM_REGS, 16, number of 32-bit registers (1..256)
- BASE_ADDR, 0, byte address of register 0; must be 4-byte aligned

Ports (data width fixed at 32, strobe width 4):
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- awaddr, awprot, awvalid / awready  in,in,in / out  ADDR_WIDTH,3,1 / 1  write address channel
- wdata, wstrb, wvalid / wready  in,in,in / out  32,4,1 / 1  write data channel
- bresp, bvalid / bready  out,out / in  2,1 / 1  write response channel
- araddr, arprot, arvalid / arready  in,in,in / out  ADDR_WIDTH,3,1 / 1  read address channel
- rdata, rresp, rvalid / rready  out,out,out / in  32,2,1 / 1  read data channel
- regs  out  32*NUM_REGS  register contents, reg i at [32*i+31:32*i]
- wr_pulse  out  NUM_REGS  one-cycle pulse on cycle after register i is written

## Operation

- Decode: index = (addr - BASE_ADDR) >> 2; addr[1:0] ignored. Index >= NUM_REGS or addr < BASE_ADDR -> out of range.
- Responses: OKAY = 2'b00, SLVERR = 2'b10. Out of range -> SLVERR; write discarded, rdata = 0.
- Write path: AW and W captured independently into holding registers (aw_held, w_held). awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
- Commit when both address and data available (held or handshaking this cycle): bytes with wstrb[k]=1 update reg[index][8k+7:8k]; wstrb = 0 is legal, no change, OKAY. Holding flags clear; bvalid set.
- Write states: W_IDLE (collecting AW/W) -> W_RESP (bvalid=1) on commit; W_RESP -> W_IDLE on bvalid && bready.
- Read states: R_IDLE (arready=1) -> R_DATA on arvalid && arready, rdata/rresp registered; R_DATA (arready=0, rvalid=1) -> R_IDLE on rready.
- rdata, rresp, bresp stable while their valid is high and ready low.
- Simultaneous read handshake and write commit to same register: read returns pre-write value.
- wr_pulse[i] asserted only for OKAY writes, even if wstrb = 0.

## Timing

- Reset (areset high, any time, including mid-transaction): awready, wready, arready, bvalid, rvalid = 0; bresp, rresp, rdata = 0; regs = 0; wr_pulse = 0; holding flags cleared, FSMs to idle. In-flight transactions are dropped.
- First cycle after areset deasserts: awready, wready, arready = 1.
- Write: AW and W handshake in cycle T -> regs updated and bvalid = 1 in T+1. W at T, AW at T+2 -> bvalid at T+3.
- B handshake at T -> awready/wready high at T+1; max write throughput one per 2 cycles.
- Read: AR handshake at T -> rvalid, rdata valid at T+1; R handshake at T+1 -> arready at T+2.
- No combinational path from any valid to any ready.

## Configuration

- AXI_REGFILE_PRIV_EN defined: access with awprot[0]=0 or arprot[0]=0 (unprivileged) gets SLVERR; write suppressed, no wr_pulse, rdata = 0.
- Not defined: awprot/arprot ignored; all in-range accesses OKAY.

## Test plan

- Reset then AW=BASE+0x8, W=0xDEADBEEF, wstrb=4'hF same cycle -> bvalid next cycle, bresp=00, regs[2]=0xDEADBEEF, wr_pulse[2] one cycle.
- W first (0x000000AA, wstrb=4'b0001 to reg 2) two cycles before AW -> regs[2]=0xDEADBEAA, awready held low while bvalid waits with bready=0 for 5 cycles.
- Read BASE+4*NUM_REGS -> rresp=10, rdata=0; write same address -> bresp=10, regs unchanged.
- Same-cycle AR and commit to reg 3 (old 0x1, new 0x2) -> rdata=0x1; subsequent read -> 0x2.
- Assert areset while bvalid=1 and rvalid=1 -> all outputs 0 immediately; readies 1 one cycle after release.
- With AXI_REGFILE_PRIV_EN, write awprot=3'b000 to reg 0 -> SLVERR, regs[0] unchanged; awprot=3'b001 -> OKAY.
